// File: rtl/mtm_alu_deserializer_pkg.sv
// Shared types, frame constants and CRC helper for the mtm_Alu receive front end.
package mtm_alu_deserializer_pkg;

    typedef enum logic [2:0] {
        AND_OP = 3'b000,
        OR_OP  = 3'b001,
        ADD_OP = 3'b100,
        SUB_OP = 3'b101
    } operation_t;

    typedef struct packed {
        logic err_data;
        logic err_crc;
        logic err_op;
    } err_flags_t;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;

    // x^4+x+1, zero init, message consumed MSB first.
    function automatic logic [3:0] crc4_68(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            AND_OP, OR_OP, ADD_OP, SUB_OP: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// Result bus from the deserializer to the ALU core and the error-response path.
interface mtm_alu_deserializer_if;

    logic [31:0]                              b_out;
    logic [31:0]                              a_out;
    logic [2:0]                               op_out;
    logic                                     out_valid;
    mtm_alu_deserializer_pkg::err_flags_t     err_flags;
    logic                                     err_valid;

    modport master (
        output b_out, a_out, op_out, out_valid, err_flags, err_valid
    );

    modport slave (
        input b_out, a_out, op_out, out_valid, err_flags, err_valid
    );

endinterface

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC-4 over the 68-bit {B, A, 1, OP} packet image.
module mtm_alu_crc4
    import mtm_alu_deserializer_pkg::*;
(
    input  logic [67:0] data_in,
    output logic [3:0]  crc_out
);

    assign crc_out = crc4_68(data_in);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial-line receiver: frames `sin` into {B, A, OP, CRC} packets and validates them.
module mtm_alu_deserializer
    import mtm_alu_deserializer_pkg::*;
#(
    parameter int DATA_FRAMES = 8,
    parameter int FRAME_BITS  = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sin,
    mtm_alu_deserializer_if.master        alu_if
);

    localparam int PAYLOAD_BITS = FRAME_BITS - 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TYPE    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;

    logic [2:0]  state;
    logic [2:0]  bit_cnt;
    logic [3:0]  frame_cnt;
    logic        pkt_corrupt;
    logic        frame_type;
    logic [7:0]  byte_sr;
    logic [63:0] opnd_sr;
    logic [3:0]  crc_calc;
    err_flags_t  chk;

    mtm_alu_crc4 u_crc4 (
        .data_in ({opnd_sr, 1'b1, byte_sr[6:4]}),
        .crc_out (crc_calc)
    );

    // Priority-resolved so at most one flag is ever set.
    always_comb begin
        chk.err_data = (frame_cnt != 4'(DATA_FRAMES)) || pkt_corrupt;
        chk.err_crc  = !chk.err_data && (crc_calc != byte_sr[3:0]);
        chk.err_op   = !chk.err_data && !chk.err_crc && !op_is_legal(byte_sr[6:4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            bit_cnt          <= '0;
            frame_cnt        <= '0;
            pkt_corrupt      <= 1'b0;
            frame_type       <= FRAME_DATA;
            alu_if.b_out     <= '0;
            alu_if.a_out     <= '0;
            alu_if.op_out    <= '0;
            alu_if.out_valid <= 1'b0;
            alu_if.err_flags <= '0;
            alu_if.err_valid <= 1'b0;
        end else begin
            alu_if.out_valid <= 1'b0;
            alu_if.err_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!sin) state <= S_TYPE;
                end
                S_TYPE: begin
                    frame_type <= sin;
                    bit_cnt    <= '0;
                    state      <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(PAYLOAD_BITS - 1)) state <= S_STOP;
                end
                S_STOP: begin
                    if (!sin || (frame_type == FRAME_CMD && byte_sr[7])) pkt_corrupt <= 1'b1;
                    if (frame_type == FRAME_DATA) begin
                        if (frame_cnt != 4'hF) frame_cnt <= frame_cnt + 4'd1;
                        state <= S_IDLE;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    frame_cnt   <= '0;
                    pkt_corrupt <= 1'b0;
                    // A start bit may already arrive here on a gapless line.
                    state       <= sin ? S_IDLE : S_TYPE;
                    if (|chk) begin
                        alu_if.err_flags <= chk;
                        alu_if.err_valid <= 1'b1;
                    end else begin
                        alu_if.b_out     <= opnd_sr[63:32];
                        alu_if.a_out     <= opnd_sr[31:0];
                        alu_if.op_out    <= byte_sr[6:4];
                        alu_if.out_valid <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload datapath; contents are qualified by the control state above.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD) byte_sr <= {byte_sr[6:0], sin};
        if (state == S_STOP && frame_type == FRAME_DATA) opnd_sr <= {opnd_sr[55:0], byte_sr};
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomized bench for mtm_alu_deserializer with a packet-level reference model.
module tb_mtm_alu_deserializer;

    typedef struct {
        int          stop_idx;
        logic        is_err;
        logic [2:0]  flags;
        logic [31:0] b;
        logic [31:0] a;
        logic [2:0]  op;
    } exp_t;

    logic clk;
    logic rst_n;
    logic sin;

    mtm_alu_deserializer_if u_if ();

    mtm_alu_deserializer #(
        .DATA_FRAMES (8),
        .FRAME_BITS  (11)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin),
        .alu_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks;
    int   n_fail;
    logic bit_q[$];
    logic rst_q[$];
    exp_t exp_q[$];

    logic [31:0] last_b;
    logic [31:0] last_a;
    logic [2:0]  last_op;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of msg * x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic push_bit(input logic v, input logic rst_v);
        bit_q.push_back(v);
        rst_q.push_back(rst_v);
    endtask

    task automatic push_frame(input logic typ, input logic [7:0] pl, input logic stop);
        push_bit(1'b0, 1'b1);
        push_bit(typ, 1'b1);
        for (int i = 7; i >= 0; i--) push_bit(pl[i], 1'b1);
        push_bit(stop, 1'b1);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_bit(1'b1, 1'b1);
    endtask

    // bad_stop: index of the frame (data frames 0.., cmd = n_data) sent with stop 0; -1 = none.
    task automatic push_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                               input int n_data, input int bad_stop, input logic [3:0] crc_flip,
                               input logic cmd_msb, input int gap);
        logic [63:0] opnd;
        logic [7:0]  pl;
        logic [3:0]  crc_rx;
        logic        data_err;
        logic        crc_err;
        logic        op_err;
        exp_t        e;
        int          k;
        opnd = {b, a};
        for (int i = 0; i < n_data; i++) begin
            k = n_data - 1 - i;
            if (k < 8) pl = opnd[8*k +: 8];
            else       pl = 8'($urandom);
            push_frame(1'b0, pl, i != bad_stop);
        end
        crc_rx = ref_crc({b, a, 1'b1, op}) ^ crc_flip;
        push_frame(1'b1, {cmd_msb, op, crc_rx}, n_data != bad_stop);
        e.stop_idx = bit_q.size() - 1;

        data_err = (n_data != 8) || (bad_stop >= 0 && bad_stop <= n_data) || cmd_msb;
        crc_err  = crc_rx != ref_crc({b, a, 1'b1, op});
        op_err   = !(op inside {3'b000, 3'b001, 3'b100, 3'b101});
        if (data_err)     e.flags = 3'b100;
        else if (crc_err) e.flags = 3'b010;
        else if (op_err)  e.flags = 3'b001;
        else              e.flags = 3'b000;
        e.is_err = (e.flags != 3'b000);
        if (!e.is_err) begin
            last_b  = b;
            last_a  = a;
            last_op = op;
        end
        e.b  = last_b;
        e.a  = last_a;
        e.op = last_op;
        exp_q.push_back(e);
        push_idle(gap);
    endtask

    // Three data frames, part of a fourth, then rst_n low for two bits.
    task automatic push_aborted_packet();
        push_frame(1'b0, 8'hAA, 1'b1);
        push_frame(1'b0, 8'h55, 1'b1);
        push_frame(1'b0, 8'h0F, 1'b1);
        push_bit(1'b0, 1'b1);
        push_bit(1'b0, 1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b0);
        last_b  = '0;
        last_a  = '0;
        last_op = '0;
    endtask

    initial begin
        int   n;
        int   bad;
        int   r;
        logic [3:0] flip;
        exp_t e;

        n_checks = 0;
        n_fail   = 0;
        last_b   = '0;
        last_a   = '0;
        last_op  = '0;
        sin      = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_b_out",     u_if.b_out,     0);
        chk_eq("rst_a_out",     u_if.a_out,     0);
        chk_eq("rst_op_out",    u_if.op_out,    0);
        chk_eq("rst_out_valid", u_if.out_valid, 0);
        chk_eq("rst_err_flags", u_if.err_flags, 0);
        chk_eq("rst_err_valid", u_if.err_valid, 0);

        push_idle(3);
        push_packet(32'h5, 32'h3, 3'b100, 8, -1, 4'h0, 1'b0, 2);
        push_packet(32'h1234, 32'h9876, 3'b111, 8, -1, 4'h0, 1'b0, 1);
        push_packet(32'hDEADBEEF, 32'h0BADF00D, 3'b101, 8, -1, 4'h1, 1'b0, 3);
        push_packet(32'h11223344, 32'h55667788, 3'b000, 7, -1, 4'h0, 1'b0, 2);
        push_packet(32'hCAFEBABE, 32'h01020304, 3'b001, 8, -1, 4'h0, 1'b0, 0);
        push_packet(32'hFFFFFFFF, 32'h00000001, 3'b100, 8, 2, 4'h0, 1'b0, 1);
        push_aborted_packet();
        push_packet(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 8, -1, 4'h0, 1'b0, 0);
        push_packet(32'h80000000, 32'h7FFFFFFF, 3'b000, 8, -1, 4'h0, 1'b0, 2);
        push_packet(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b100, 10, -1, 4'h0, 1'b0, 1);
        push_packet(32'h13579BDF, 32'h2468ACE0, 3'b001, 8, -1, 4'h0, 1'b1, 1);
        push_packet(32'h0000FFFF, 32'hFFFF0000, 3'b101, 8, 8, 4'h0, 1'b0, 1);
        push_packet(32'h00000000, 32'h00000000, 3'b001, 8, -1, 4'h0, 1'b0, 1);

        for (int p = 0; p < 30; p++) begin
            r    = int'($urandom_range(0, 9));
            n    = (r == 0) ? 7 : (r == 1) ? 9 : 8;
            bad  = (r == 2) ? int'($urandom_range(0, n)) : -1;
            flip = (r == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
            push_packet($urandom, $urandom, 3'($urandom_range(0, 7)), n, bad, flip,
                        (r == 4), int'($urandom_range(0, 2)));
        end
        push_idle(4);

        for (int idx = 0; idx < bit_q.size(); idx++) begin
            @(negedge clk);
            sin   = bit_q[idx];
            rst_n = rst_q[idx];
            @(posedge clk);
            #1;
            if (exp_q.size() > 0 && exp_q[0].stop_idx == idx - 1) begin
                e = exp_q.pop_front();
                chk_eq("out_valid", u_if.out_valid, !e.is_err);
                chk_eq("err_valid", u_if.err_valid, e.is_err);
                if (e.is_err) chk_eq("err_flags", u_if.err_flags, e.flags);
                chk_eq("b_out",  u_if.b_out,  e.b);
                chk_eq("a_out",  u_if.a_out,  e.a);
                chk_eq("op_out", u_if.op_out, e.op);
            end else begin
                chk_eq("idle_out_valid", u_if.out_valid, 0);
                chk_eq("idle_err_valid", u_if.err_valid, 0);
            end
        end
        chk_eq("pending_strobes", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
